// File: rtl/cwc_trace_reader.sv
// ChipWatcher trace readout engine: reads capture RAM in circular order from the oldest
// sample and streams a header byte followed by each sample as little-endian bytes.
module cwc_trace_reader #(
  parameter int         RAM_LEN        = 167,
  parameter int         RAM_DATA_DEPTH = 16384,
  parameter int         ADDR_W         = 14,
  parameter logic [7:0] HDR_BYTE       = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W:0]    num_samples,
  input  logic               abort,
  output logic               ram_rd_en,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  input  logic [RAM_LEN-1:0] ram_rd_data,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int BPS   = (RAM_LEN + 7) / 8;
  localparam int SH_W  = BPS * 8;
  localparam int CNT_W = $clog2(BPS + 1);
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W + 1)'(RAM_DATA_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_READ, S_WAIT, S_SEND} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [SH_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
  logic              done_int;
  logic              xfer;

  // All stream/RAM outputs decode the registered state only, so out_ready never reaches out_valid.
  assign out_valid   = (state_reg == S_HDR) || (state_reg == S_SEND);
  assign ram_rd_en   = (state_reg == S_READ);
  assign ram_rd_addr = (state_reg == S_READ) ? rd_ptr_reg : '0;
  assign busy        = (state_reg != S_IDLE);
  assign xfer        = out_valid && out_ready;
  assign done        = done_int && !rst;

  always_comb begin
    out_data = 8'h00;
    case (state_reg)
      S_HDR:   out_data = HDR_BYTE;
      S_SEND:  out_data = shift_reg[7:0];
      default: out_data = 8'h00;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    rd_ptr_next    = rd_ptr_reg;
    remaining_next = remaining_reg;
    shift_next     = shift_reg;
    byte_cnt_next  = byte_cnt_reg;
    done_int       = 1'b0;
    if (abort && state_reg != S_IDLE) begin
      // abort wins over a transfer in the same cycle; partial sample is dropped
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            rd_ptr_next    = start_addr;
            remaining_next = (num_samples > DEPTH_V) ? DEPTH_V : num_samples;
            state_next     = S_HDR;
          end
        end
        S_HDR: begin
          if (xfer) begin
            if (remaining_reg == '0) begin
              done_int   = 1'b1;
              state_next = S_IDLE;
            end else begin
              state_next = S_READ;
            end
          end
        end
        S_READ: state_next = S_WAIT;
        S_WAIT: begin
          shift_next     = SH_W'(ram_rd_data);
          byte_cnt_next  = '0;
          rd_ptr_next    = rd_ptr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - (ADDR_W + 1)'(1);
          state_next     = S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            shift_next    = shift_reg >> 8;
            byte_cnt_next = byte_cnt_reg + CNT_W'(1);
            if (byte_cnt_reg == LAST_CNT) begin
              if (remaining_reg == '0) begin
                done_int   = 1'b1;
                state_next = S_IDLE;
              end else begin
                state_next = S_READ;
              end
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rd_ptr_reg    <= '0;
      remaining_reg <= '0;
      shift_reg     <= '0;
      byte_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rd_ptr_reg    <= rd_ptr_next;
      remaining_reg <= remaining_next;
      shift_reg     <= shift_next;
      byte_cnt_reg  <= byte_cnt_next;
    end
  end

endmodule

// File: tb/tb_cwc_trace_reader.sv
// Directed, table-driven bench for cwc_trace_reader: each vector is one readout compared
// against a byte-stream model built from the bench's own RAM image.
module tb_cwc_trace_reader;
  localparam int RL  = 167;
  localparam int D   = 16384;
  localparam int AW  = 14;
  localparam int BPS = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, out_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_samples;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [RL-1:0] ram_rd_data;
  logic [7:0]    out_data;
  logic          out_valid, busy, done;
  logic [RL-1:0] mem [0:D-1];

  cwc_trace_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_samples(num_samples),
    .abort(abort), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  // Small-depth instance so the clamp case finishes in a few hundred cycles.
  logic          s_start, s_abort, s_ready, s_rd_en, s_valid, s_busy, s_done;
  logic [3:0]    s_addr, s_rd_addr;
  logic [4:0]    s_num;
  logic [RL-1:0] s_rd_data;
  logic [7:0]    s_data;
  logic [RL-1:0] s_mem [0:15];

  cwc_trace_reader #(.RAM_LEN(RL), .RAM_DATA_DEPTH(16), .ADDR_W(4)) sdut (
    .clk(clk), .rst(rst), .start(s_start), .start_addr(s_addr), .num_samples(s_num),
    .abort(s_abort), .ram_rd_en(s_rd_en), .ram_rd_addr(s_rd_addr), .ram_rd_data(s_rd_data),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready), .busy(s_busy), .done(s_done)
  );
  always @(posedge clk) if (s_rd_en) s_rd_data <= s_mem[s_rd_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int addr; int n; int mode; int abort_at; int use_rst; int start_at; int exp_bytes;
  } vec_t;
  vec_t vecs[8];

  logic [7:0] bytes[$];
  logic [7:0] exp_q[$];
  int         addr_q[$];
  int         done_cnt, done_cyc, first_rd, stab_err, end_cyc, last_xfer;
  bit         was_aborted;

  task automatic build_exp(input int a, input int n);
    logic [167:0] e;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      e = {1'b0, mem[(a + i) % D]};
      for (int b = 0; b < BPS; b++) exp_q.push_back(e[8*b +: 8]);
    end
  endtask

  task automatic run_main(input vec_t v);
    int         lfsr;
    logic [7:0] pdata;
    bit         pvalid, pready;
    bytes.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; first_rd = -1; stab_err = 0; end_cyc = -1; last_xfer = -1;
    was_aborted = 0; pvalid = 0; pready = 0; pdata = 8'h00; lfsr = 32'h1234 + v.addr;
    @(negedge clk);
    start_addr = v.addr[AW-1:0]; num_samples = v.n[AW:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      lfsr = lfsr * 1103515245 + 12345;
      out_ready = (v.mode == 0) ? 1'b1 : lfsr[16];
      if (cyc == v.start_at) begin
        start = 1'b1; start_addr = '0; num_samples = 15'd1;
      end
      if (out_valid && out_ready && bytes.size() == v.abort_at) begin
        if (v.use_rst != 0) rst = 1'b1; else abort = 1'b1;
        was_aborted = 1;
      end
      #1;
      if (cyc == 0) begin
        chk("hdr_busy", longint'(busy), 1);
        chk("hdr_valid", longint'(out_valid), 1);
        chk("hdr_data", longint'(out_data), 64'hA5);
      end
      if (ram_rd_en) begin
        addr_q.push_back(int'(ram_rd_addr));
        if (first_rd < 0) first_rd = cyc;
      end
      if (pvalid && !pready && (!out_valid || out_data != pdata)) stab_err++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid && out_ready && !was_aborted) begin
        bytes.push_back(out_data);
        last_xfer = cyc;
      end
      pvalid = out_valid; pready = out_ready; pdata = out_data;
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      if (was_aborted) begin
        #1;
        chk("abort_valid", longint'(out_valid), 0);
        chk("abort_busy", longint'(busy), 0);
        break;
      end
      if (!busy) begin end_cyc = cyc + 1; break; end
    end
    if (!was_aborted && end_cyc < 0) chk("timeout", 0, 1);
  endtask

  initial begin
    logic [191:0] r;
    int nb, s_cnt, s_rd_cnt, s_done_cnt;
    for (int i = 0; i < D; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      mem[i] = r[RL-1:0];
    end
    for (int i = 0; i < 16; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      s_mem[i] = r[RL-1:0];
    end
    mem[5] = 167'h1;
    mem[6] = '1;

    // addr, n, mode, abort_at, use_rst, start_at, exp_bytes
    vecs[0] = '{5,     2, 0, -1, 0, -1, 43};
    vecs[1] = '{16382, 3, 0, -1, 0, -1, 64};
    vecs[2] = '{5,     2, 1, -1, 0, -1, 43};
    vecs[3] = '{100,   0, 0, -1, 0, -1, 1};
    vecs[4] = '{5,     2, 0, -1, 0,  7, 43};
    vecs[5] = '{5,     2, 0, 11, 0, -1, 11};
    vecs[6] = '{5,     2, 0, 11, 1, -1, 11};
    vecs[7] = '{16380, 6, 1, -1, 0, 30, 127};

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; num_samples = '0;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1; s_addr = '0; s_num = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", longint'(ram_rd_en), 0);
    chk("rst_rd_addr", longint'(ram_rd_addr), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      build_exp(vecs[i].addr, vecs[i].n);
      run_main(vecs[i]);
      chk("byte_count", longint'(bytes.size()), longint'(vecs[i].exp_bytes));
      nb = 0;
      for (int k = 0; k < bytes.size() && k < exp_q.size(); k++) if (bytes[k] != exp_q[k]) nb++;
      chk("stream_bytes_wrong", longint'(nb), 0);
      chk("stable_under_stall", longint'(stab_err), 0);
      if (vecs[i].abort_at >= 0) begin
        chk("abort_no_done", longint'(done_cnt), 0);
        chk("abort_rd_count", longint'(addr_q.size()), 1);
      end else begin
        chk("done_count", longint'(done_cnt), 1);
        chk("done_on_last_xfer", longint'(done_cyc), longint'(last_xfer));
        chk("busy_falls_after_done", longint'(end_cyc), longint'(done_cyc + 1));
        chk("rd_count", longint'(addr_q.size()), longint'(vecs[i].n));
        nb = 0;
        for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] != (vecs[i].addr + k) % D) nb++;
        chk("rd_addr_seq", longint'(nb), 0);
        if (vecs[i].mode == 0) begin
          chk("readout_cycles", longint'(done_cyc), longint'(23 * vecs[i].n));
          if (vecs[i].n > 0) chk("first_rd_latency", longint'(first_rd), 1);
        end
      end
      if (i == 0) begin
        chk("basic_byte1", longint'(bytes[1]), 64'h01);
        chk("basic_byte21", longint'(bytes[21]), 64'h00);
        chk("basic_byte22", longint'(bytes[22]), 64'hFF);
        chk("basic_byte42", longint'(bytes[42]), 64'h7F);
      end
      if (i == 1) chk("wrap_third_addr", longint'(addr_q[2]), 0);
      $display("vec %0d: addr=%0d n=%0d mode=%0d bytes=%0d done=%0d rd=%0d",
               i, vecs[i].addr, vecs[i].n, vecs[i].mode, bytes.size(), done_cnt, addr_q.size());
    end

    // Clamp: 20 requested on a 16-deep RAM -> 16 samples, 1 + 16*21 bytes.
    s_cnt = 0; s_rd_cnt = 0; s_done_cnt = 0;
    @(negedge clk);
    s_addr = 4'd3; s_num = 5'd20; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      #1;
      if (s_valid && s_ready) s_cnt++;
      if (s_rd_en) s_rd_cnt++;
      if (s_done) s_done_cnt++;
      @(negedge clk);
      if (!s_busy) break;
    end
    chk("clamp_bytes", longint'(s_cnt), 337);
    chk("clamp_reads", longint'(s_rd_cnt), 16);
    chk("clamp_done", longint'(s_done_cnt), 1);
    chk("clamp_idle", longint'(s_busy), 0);
    $display("clamp: bytes=%0d reads=%0d done=%0d", s_cnt, s_rd_cnt, s_done_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cwc_trace_reader.md
# cwc_trace_reader

Readout engine for the ChipWatcher capture RAM. After a capture completes, it reads samples out of the trace RAM's read port in circular order, starting at the oldest sample, and serializes each `RAM_LEN`-bit sample into a little-endian byte stream with valid/ready handshake. It sits between the capture hub's RAM read port and the host-link byte transmitter. It is the read-side counterpart of the capture path that writes probe data into the RAM.

## Interface
- `RAM_LEN`, 167: sample width in bits, equal to the capture hub's `RAM_LEN`.
- `RAM_DATA_DEPTH`, 16384: RAM depth in samples; must be a power of two.
- `ADDR_W`, 14: log2(`RAM_DATA_DEPTH`).
- `BPS`, (`RAM_LEN`+7)/8 = 21: bytes per sample (derived localparam).
- `HDR_BYTE`, 8'hA5: frame header byte.

Ports:
- `clk` in, 1: single clock, same domain as the RAM read port.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: single-cycle request to begin a readout; honoured only in IDLE.
- `start_addr` in, `ADDR_W`: address of the oldest sample; sampled on an accepted `start`.
- `num_samples` in, `ADDR_W`+1: number of samples to send; sampled on `start`; values above `RAM_DATA_DEPTH` are clamped to `RAM_DATA_DEPTH`.
- `abort` in, 1: terminates the readout; returns to IDLE on the next cycle.
- `ram_rd_en` out, 1: RAM read strobe.
- `ram_rd_addr` out, `ADDR_W`: RAM read address.
- `ram_rd_data` in, `RAM_LEN`: RAM read data, valid the cycle after `ram_rd_en`.
- `out_data` out, 8: stream byte.
- `out_valid` out, 1: byte valid.
- `out_ready` in, 1: sink accepts the byte; a transfer occurs when `out_valid` and `out_ready` are both high.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse on normal completion; not raised on abort.

## Operation
- **States.** IDLE, HDR, READ, WAIT, SEND.
- **IDLE.**
  - On `start`: latch `start_addr` into `rd_ptr`, latch the clamped `num_samples` into `remaining`, then go to HDR.
  - `start` in any other state is ignored.
- **HDR.**
  - Drive `out_valid`=1 and `out_data`=`HDR_BYTE`.
  - On transfer: if `remaining`==0, pulse `done` and go to IDLE; otherwise go to READ.
- **READ.** Drive `ram_rd_en`=1 and `ram_rd_addr`=`rd_ptr` for exactly one cycle, then go to WAIT.
- **WAIT.**
  - Load `ram_rd_data` into the shift register, zero-extended to `BPS`*8 bits.
  - Clear `byte_cnt`; increment `rd_ptr` modulo `RAM_DATA_DEPTH` (16383 wraps to 0); decrement `remaining`.
  - Go to SEND.
- **SEND.**
  - Drive `out_valid`=1 and `out_data`=shift[7:0]; least-significant byte goes first.
  - On transfer: shift right by 8 and increment `byte_cnt`.
  - On the transfer with `byte_cnt`==`BPS`-1: if `remaining`==0, pulse `done` and go to IDLE; otherwise go to READ.
  - The final byte of a sample carries zero padding in bits above `RAM_LEN` mod 8 (bits [7:7] for 167).
- **Abort.** `abort` in any non-IDLE state forces IDLE on the next cycle with `out_valid`=0 and `ram_rd_en`=0. Any partially sent sample is discarded. `abort` takes priority over a simultaneous transfer.
- **Stability.** While `out_valid`=1 and `out_ready`=0, `out_data` must hold stable. `out_valid` never drops without a transfer, except on abort or reset.
- **Reset.**
  - All outputs go to 0: `ram_rd_en`, `ram_rd_addr`, `out_data`, `out_valid`, `busy`, `done`.
  - State goes to IDLE and counters clear.
  - Reset mid-readout behaves like abort, including no `done`.

## Timing
- Readout latencies:
  - `start` high at cycle t: `busy`=1 and header valid at t+1.
  - Header transfer at cycle h: `ram_rd_en` at h+1, first data byte valid at h+3.
  - Last byte of a sample transferred at cycle s: next `ram_rd_en` at s+1, next first byte at s+3.
- With `out_ready` held high, a sample costs `BPS`+2 = 23 cycles, and a readout of N samples costs 1+23N cycles from HDR entry to the `done` cycle.
- The `done` pulse coincides with the final transfer cycle. `busy` falls the cycle after that.
- `out_valid` is registered; there is no combinational path from `out_ready` to `out_valid`.

## Test plan
- **Basic readout.** RAM[5]=167'h1, RAM[6]=all ones; `start_addr`=5, `num_samples`=2, `out_ready`=1 -> stream is A5, then 01 followed by 20 bytes of 00, then 20 bytes of FF followed by 7F. `done` asserts on byte 43 and `busy` drops the next cycle.
- **Address wrap.** `start_addr`=16382, `num_samples`=3 -> `ram_rd_addr` sequence is 16382, 16383, 0 -> 64 bytes total.
- **Backpressure.** Toggle `out_ready` pseudo-randomly -> byte stream identical to the basic case; `out_data` stable whenever valid && !ready.
- **Zero samples.** `num_samples`=0 -> only A5 is sent; `ram_rd_en` never asserts; `done` asserts with the A5 transfer.
- **Abort / reset.** Assert `abort` on byte 10 of sample 0 -> next cycle `out_valid`=0 and `busy`=0, with no `done`. Repeat the test using `rst` instead of `abort` and get the same result.
- **Start handling and clamp.**
  - `start` pulsed while busy -> ignored; the current stream is unchanged.
  - `num_samples`=20000 -> clamped to 16384 samples (344065 bytes).
